mm_feedback_judge: RTL and testbench
====================================

Name: mm_feedback_judge

Overview:
- Scoring side of the four-peg code-breaking game: holds the loaded secret, accepts guesses through a valid/ready handshake, and scores each guess.
- Returns red (right colour, right position) and white (right colour, wrong position) peg counts, tracks attempts, and declares win or lose.
- Sits between the peg-entry front end, which supplies the packed secret/guess, and the LED/feedback display.

Parameters:
- COLOR_W, 3, bits per peg colour (8 colours).
- MAX_GUESSES, 10, attempts allowed before lose.
- ATTEMPT_W, 4, width of the attempt counter; must hold MAX_GUESSES.

Ports:
- clk  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- secret_load  input  1  one-cycle strobe: capture secret and start a new game.
- secret  input  4*COLOR_W  packed code; peg1 in MSBs, peg4 in LSBs.
- guess_valid  input  1  guess offered.
- guess_ready  output  1  judge can accept a guess.
- guess  input  4*COLOR_W  packed guess, same packing as secret.
- fb_valid  output  1  one-cycle pulse: red/white valid for the latest guess.
- red  output  3  exact-match count, 0..4.
- white  output  3  colour-only match count, 0..4.
- attempts  output  ATTEMPT_W  guesses scored this game.
- win  output  1  held high after a 4-red result.
- lose  output  1  held high after MAX_GUESSES scored without a win.
- busy  output  1  scoring in progress.

Behaviour:
- Reset (async): state=IDLE; guess_ready, fb_valid, red, white, attempts, win, lose, busy all 0; secret register 0.
- States: IDLE (no secret), ARMED, RED_PASS, WHITE_PASS, REPORT, WON, LOST.
- secret_load in any state:
  - captures secret next edge, goes to ARMED.
  - clears attempts, red, white, win, lose.
  - aborts any scoring pass with no fb_valid.
  - has priority over guess_valid in the same cycle.
- guess_ready = (state==ARMED) && !secret_load, combinational. Acceptance = guess_valid && guess_ready at edge N. Guess is captured into an internal register; the guess input is ignored afterwards.
- RED_PASS (edges N+1..N+4, one peg i=0..3 per cycle):
  - if g[i]==s[i]: red++, and set s_used[i] and g_used[i].
  - red and white are cleared at edge N.
- WHITE_PASS (edges N+5..N+8, one guess peg i per cycle):
  - only if !g_used[i]: find the lowest j with !s_used[j] && s[j]==g[i].
  - if found: s_used[j]=1 and white++.
  - Duplicate colours are counted at most once per secret peg.
- REPORT (edge N+9):
  - fb_valid=1 for exactly one cycle; attempts++ (saturating at MAX_GUESSES).
  - If red==4 go to WON. Else if the new attempts==MAX_GUESSES go to LOST. Else go to ARMED.
- Latency: acceptance edge to fb_valid high = 9 clocks; next guess can be accepted at edge N+10 at the earliest.
- busy=1 in RED_PASS, WHITE_PASS, REPORT.
- red/white hold their last value until the next acceptance or secret_load.
- WON/LOST: guess_ready=0; win or lose is held until secret_load or Reset.
- guess_valid in IDLE, WON, LOST or while busy: ignored, no state change.
- Reset mid-pass: everything returns to reset values immediately; no fb_valid.
- Colours are plain COLOR_W-bit values; all 2^COLOR_W codes are legal.

Decomposition:
- Shared package mm_pkg: PEGS=4; the state enum; the feedback count width (3); a pack/unpack function for peg index to bit slice (peg1 in MSBs).
- One sub-module, mm_first_unused_match: combinational lowest-index search over 4 secret pegs.
  - Inputs: colour, s, s_used.
  - Outputs: found, index.
  - Used by WHITE_PASS.

Test Plan:
- Reset, then load secret 1,2,3,4; guess 1,2,3,4 -> fb_valid exactly 9 clocks after acceptance; red=4, white=0, attempts=1, win=1, guess_ready=0.
- Secret 1,2,3,4; guess 4,3,2,1 -> red=0, white=4, attempts=1, state returns to ARMED (guess_ready=1).
- Secret 1,1,2,2; guess 1,2,1,1 -> red=1, white=2; then guess 5,5,5,5 -> red=0, white=0.
- Secret 0,0,0,0; 10 guesses of 7,7,7,7 -> each red=0, white=0; after the 10th: attempts=10, lose=1, guess_ready=0. An 11th guess_valid is ignored.
- Mid-pass abort:
  - secret_load asserted 3 clocks after acceptance -> no fb_valid; attempts=0; ARMED with the new secret.
  - Repeat with async Reset pulsed mid-pass, away from any clock edge -> all outputs 0 immediately; IDLE.
- Priority: secret_load and guess_valid in the same cycle -> guess_ready=0 that cycle; guess not accepted; new secret captured.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the code-breaking feedback judge.
// Holds the peg count, feedback count width, FSM state type and the
// peg-index to bit-slice mapping used when unpacking secret/guess codes.
package mm_pkg;

  localparam int PEGS      = 4;
  localparam int PEG_IDX_W = 2;
  localparam int FB_W      = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RED_PASS,
    S_WHITE_PASS,
    S_REPORT,
    S_WON,
    S_LOST
  } mm_state_t;

  // Peg 0 (peg1) sits in the MSBs of a packed code.
  function automatic int peg_lsb(input int idx, input int color_w);
    return (PEGS - 1 - idx) * color_w;
  endfunction

endpackage

// File: rtl/mm_first_unused_match.sv
// Combinational search for the lowest-index secret peg that still has not
// been consumed and carries the requested colour.
// Ports:
//   colour  - guess peg colour to look for
//   s       - packed secret code (peg1 in MSBs)
//   s_used  - per-peg consumed flags, bit i = peg i
//   found   - a matching unused peg exists
//   index   - lowest matching peg index (0 when none found)
module mm_first_unused_match
  import mm_pkg::*;
#(
  parameter int COLOR_W = 3
) (
  input  logic [COLOR_W-1:0]      colour,
  input  logic [PEGS*COLOR_W-1:0] s,
  input  logic [PEGS-1:0]         s_used,
  output logic                    found,
  output logic [PEG_IDX_W-1:0]    index
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int j = PEGS - 1; j >= 0; j--) begin
      if (!s_used[j] && (s[peg_lsb(j, COLOR_W) +: COLOR_W] == colour)) begin
        found = 1'b1;
        index = PEG_IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mm_feedback_judge.sv
// Scoring judge for the four-peg code-breaking game. Holds the secret,
// accepts one guess at a time, scores red/white pegs over two serial
// passes and reports the result with a one-cycle fb_valid pulse.
// Ports:
//   clk, Reset            - clock, async active-high reset
//   secret_load, secret   - strobe that captures a new secret and starts a game
//   guess_valid/ready     - guess handshake, guess captured on acceptance
//   fb_valid, red, white  - per-guess result pulse and peg counts
//   attempts, win, lose   - game progress and outcome flags
//   busy                  - scoring pass in progress
//
// state        | meaning
// S_IDLE       | no secret loaded yet
// S_ARMED      | secret held, waiting for a guess
// S_RED_PASS   | exact-position compare, one peg per cycle
// S_WHITE_PASS | colour-only compare over unconsumed pegs, one per cycle
// S_REPORT     | publish result, bump attempts, decide outcome
// S_WON        | four reds seen, holding win
// S_LOST       | out of attempts, holding lose
module mm_feedback_judge
  import mm_pkg::*;
#(
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 10,
  parameter int ATTEMPT_W   = 4
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    secret_load,
  input  logic [PEGS*COLOR_W-1:0] secret,
  input  logic                    guess_valid,
  output logic                    guess_ready,
  input  logic [PEGS*COLOR_W-1:0] guess,
  output logic                    fb_valid,
  output logic [FB_W-1:0]         red,
  output logic [FB_W-1:0]         white,
  output logic [ATTEMPT_W-1:0]    attempts,
  output logic                    win,
  output logic                    lose,
  output logic                    busy
);

  mm_state_t state_q, state_d;

  logic [PEGS*COLOR_W-1:0] secret_q, guess_q;
  logic [COLOR_W-1:0]      s_arr [PEGS];
  logic [COLOR_W-1:0]      g_arr [PEGS];
  logic [PEGS-1:0]         s_used, g_used;
  logic [PEG_IDX_W-1:0]    peg_idx;
  logic                    peg_last;
  logic                    accept;
  logic                    match_found;
  logic [PEG_IDX_W-1:0]    match_idx;
  logic [ATTEMPT_W-1:0]    attempts_nx;
  logic                    all_red;

  always_comb begin
    for (int i = 0; i < PEGS; i++) begin
      s_arr[i] = secret_q[peg_lsb(i, COLOR_W) +: COLOR_W];
      g_arr[i] = guess_q[peg_lsb(i, COLOR_W) +: COLOR_W];
    end
  end

  assign peg_last    = (peg_idx == PEG_IDX_W'(PEGS - 1));
  assign attempts_nx = (attempts == ATTEMPT_W'(MAX_GUESSES)) ? attempts
                                                             : attempts + ATTEMPT_W'(1);
  assign all_red     = (red == FB_W'(PEGS));

  mm_first_unused_match #(
    .COLOR_W (COLOR_W)
  ) u_match (
    .colour (g_arr[peg_idx]),
    .s      (secret_q),
    .s_used (s_used),
    .found  (match_found),
    .index  (match_idx)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    guess_ready = 1'b0;
    accept      = 1'b0;
    busy        = 1'b0;
    if (secret_load) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED:      if (guess_valid) state_d = S_RED_PASS;
        S_RED_PASS:   if (peg_last) state_d = S_WHITE_PASS;
        S_WHITE_PASS: if (peg_last) state_d = S_REPORT;
        S_REPORT: begin
          if (all_red) begin
            state_d = S_WON;
          end else if (attempts_nx == ATTEMPT_W'(MAX_GUESSES)) begin
            state_d = S_LOST;
          end else begin
            state_d = S_ARMED;
          end
        end
        default: state_d = state_q;
      endcase
    end
    guess_ready = (state_q == S_ARMED) && !secret_load;
    accept      = guess_valid && guess_ready;
    busy        = (state_q == S_RED_PASS) || (state_q == S_WHITE_PASS) ||
                  (state_q == S_REPORT);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      secret_q <= '0;
      guess_q  <= '0;
      s_used   <= '0;
      g_used   <= '0;
      peg_idx  <= '0;
      red      <= '0;
      white    <= '0;
      attempts <= '0;
      win      <= 1'b0;
      lose     <= 1'b0;
      fb_valid <= 1'b0;
    end else if (secret_load) begin
      // New game: any pass in flight is dropped without a result.
      secret_q <= secret;
      s_used   <= '0;
      g_used   <= '0;
      peg_idx  <= '0;
      red      <= '0;
      white    <= '0;
      attempts <= '0;
      win      <= 1'b0;
      lose     <= 1'b0;
      fb_valid <= 1'b0;
    end else begin
      fb_valid <= 1'b0;
      case (state_q)
        S_ARMED: begin
          if (accept) begin
            guess_q <= guess;
            s_used  <= '0;
            g_used  <= '0;
            peg_idx <= '0;
            red     <= '0;
            white   <= '0;
          end
        end
        S_RED_PASS: begin
          if (g_arr[peg_idx] == s_arr[peg_idx]) begin
            red             <= red + FB_W'(1);
            s_used[peg_idx] <= 1'b1;
            g_used[peg_idx] <= 1'b1;
          end
          peg_idx <= peg_idx + PEG_IDX_W'(1);
        end
        S_WHITE_PASS: begin
          if (!g_used[peg_idx] && match_found) begin
            s_used[match_idx] <= 1'b1;
            white             <= white + FB_W'(1);
          end
          peg_idx <= peg_idx + PEG_IDX_W'(1);
        end
        S_REPORT: begin
          fb_valid <= 1'b1;
          attempts <= attempts_nx;
          if (all_red) begin
            win <= 1'b1;
          end else if (attempts_nx == ATTEMPT_W'(MAX_GUESSES)) begin
            lose <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_feedback_judge.sv
// Scoreboard bench for mm_feedback_judge: drivers push the expected result
// of every accepted guess; a negedge monitor pops and compares on fb_valid.
module tb_mm_feedback_judge;

  localparam int CW   = 3;
  localparam int MAXG = 10;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          secret_load = 1'b0;
  logic          guess_valid = 1'b0;
  logic [11:0]   secret = '0;
  logic [11:0]   guess = '0;
  logic          guess_ready, fb_valid, win, lose, busy;
  logic [2:0]    red, white;
  logic [AW-1:0] attempts;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int acc;
    int r;
    int w;
    int att;
    int win;
    int lose;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  logic [11:0] m_secret = '0;
  bit          m_loaded = 0;
  bit          m_win = 0;
  bit          m_lose = 0;
  int          m_att = 0;
  int          last_acc = -100;

  mm_feedback_judge #(
    .COLOR_W     (CW),
    .MAX_GUESSES (MAXG),
    .ATTEMPT_W   (AW)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .secret_load (secret_load),
    .secret      (secret),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .guess       (guess),
    .fb_valid    (fb_valid),
    .red         (red),
    .white       (white),
    .attempts    (attempts),
    .win         (win),
    .lose        (lose),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
    return {3'(a), 3'(b), 3'(c), 3'(d)};
  endfunction

  function automatic logic [11:0] rcode(input int maxc);
    logic [11:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v = {v[8:0], 3'($urandom_range(0, maxc))};
    return v;
  endfunction

  // Reference scoring: exact matches, then colour-multiset overlap minus exact.
  function automatic void score(input logic [11:0] s, input logic [11:0] g,
                                output int r, output int w);
    int cs[8];
    int cg[8];
    int tot;
    logic [2:0] sp, gp;
    r = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin
      cs[c] = 0;
      cg[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      sp = s[11-3*i -: 3];
      gp = g[11-3*i -: 3];
      if (sp == gp) r++;
      cs[sp]++;
      cg[gp]++;
    end
    for (int c = 0; c < 8; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
    w = tot - r;
  endfunction

  function automatic bit m_ready();
    return m_loaded && !m_win && !m_lose && (cyc >= last_acc + 9);
  endfunction

  always @(negedge clk) begin
    if (!Reset && fb_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_fb_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("fb_latency", cyc - mon_e.acc, 9);
        chk("red", int'(red), mon_e.r);
        chk("white", int'(white), mon_e.w);
        chk("attempts", int'(attempts), mon_e.att);
        chk("win", int'(win), mon_e.win);
        chk("lose", int'(lose), mon_e.lose);
        chk("ready_after_fb", int'(guess_ready), (mon_e.win != 0 || mon_e.lose != 0) ? 0 : 1);
      end
    end
  end

  task automatic send_guess(input logic [11:0] g);
    bit   done;
    int   r, w;
    exp_t e;
    done = 0;
    guess = g;
    guess_valid = 1'b1;
    for (int k = 0; k < 30 && !done; k++) begin
      #1;
      chk("guess_ready", int'(guess_ready), m_ready() ? 1 : 0);
      if (m_ready()) begin
        score(m_secret, g, r, w);
        m_att = (m_att < MAXG) ? m_att + 1 : m_att;
        e.acc = cyc + 1;
        e.r = r;
        e.w = w;
        e.att = m_att;
        e.win = (r == 4) ? 1 : 0;
        e.lose = (r != 4 && m_att == MAXG) ? 1 : 0;
        m_win = (e.win != 0);
        m_lose = (e.lose != 0);
        last_acc = cyc + 1;
        q.push_back(e);
        done = 1;
      end
      @(negedge clk);
    end
    guess_valid = 1'b0;
    guess = 12'($urandom);
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_fb();
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (q.size() != 0) begin
      chk("fb_timeout", 0, 1);
      q.delete();
    end
  endtask

  task automatic offer_ignored(input logic [11:0] g, input int n);
    guess = g;
    guess_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("ignored_ready", int'(guess_ready), 0);
      @(negedge clk);
    end
    guess_valid = 1'b0;
    #1;
    chk("ignored_attempts", int'(attempts), m_att);
    chk("ignored_busy", int'(busy), 0);
  endtask

  task automatic load_secret(input logic [11:0] s);
    secret = s;
    secret_load = 1'b1;
    #1;
    chk("ready_during_load", int'(guess_ready), 0);
    @(negedge clk);
    secret_load = 1'b0;
    guess_valid = 1'b0;
    secret = 12'($urandom);
    m_secret = s;
    m_loaded = 1;
    m_win = 0;
    m_lose = 0;
    m_att = 0;
    last_acc = -100;
    #1;
    chk("load_attempts", int'(attempts), 0);
    chk("load_red", int'(red), 0);
    chk("load_white", int'(white), 0);
    chk("load_winlose", int'({win, lose}), 0);
    chk("load_ready", int'(guess_ready), 1);
    chk("load_busy", int'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rs, rg;
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", int'({guess_ready, fb_valid, red, white, attempts, win, lose, busy}), 0);
    Reset = 1'b0;

    offer_ignored(pk(1, 2, 3, 4), 3);

    load_secret(pk(1, 2, 3, 4));
    send_guess(pk(1, 2, 3, 4));
    wait_fb();
    offer_ignored(pk(1, 2, 3, 4), 3);

    load_secret(pk(1, 2, 3, 4));
    send_guess(pk(4, 3, 2, 1));
    wait_fb();

    load_secret(pk(1, 1, 2, 2));
    send_guess(pk(1, 2, 1, 1));
    send_guess(pk(5, 5, 5, 5));
    wait_fb();

    load_secret(pk(0, 0, 0, 0));
    repeat (10) send_guess(pk(7, 7, 7, 7));
    wait_fb();
    offer_ignored(pk(0, 0, 0, 0), 4);

    // Abort a pass with a new secret three clocks after acceptance.
    load_secret(pk(1, 2, 3, 4));
    send_guess(pk(1, 2, 3, 4));
    @(negedge clk);
    @(negedge clk);
    chk("busy_mid_pass", int'(busy), 1);
    void'(q.pop_back());
    load_secret(pk(6, 6, 5, 5));
    repeat (12) @(negedge clk);
    chk("abort_attempts", int'(attempts), 0);
    send_guess(pk(6, 5, 5, 6));
    wait_fb();

    // Async reset in the middle of a pass, away from clock edges.
    send_guess(pk(1, 1, 1, 1));
    @(posedge clk);
    @(posedge clk);
    #3;
    Reset = 1'b1;
    #1;
    chk("async_rst_outputs", int'({guess_ready, fb_valid, red, white, attempts, win, lose, busy}), 0);
    q.delete();
    m_loaded = 0;
    m_att = 0;
    m_win = 0;
    m_lose = 0;
    @(negedge clk);
    Reset = 1'b0;
    offer_ignored(pk(6, 6, 5, 5), 3);

    // secret_load and guess_valid together: the load wins.
    load_secret(pk(2, 2, 2, 2));
    guess = pk(2, 2, 2, 2);
    guess_valid = 1'b1;
    load_secret(pk(3, 4, 5, 6));
    repeat (12) @(negedge clk);
    chk("priority_attempts", int'(attempts), 0);
    send_guess(pk(3, 4, 5, 6));
    wait_fb();

    for (int gm = 0; gm < 6; gm++) begin
      rs = rcode((gm < 3) ? 3 : 7);
      load_secret(rs);
      while (!m_win && !m_lose) begin
        rg = ($urandom_range(0, 7) == 0) ? rs : rcode((gm < 3) ? 3 : 7);
        send_guess(rg);
      end
      wait_fb();
      offer_ignored(rcode(7), 2);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
